// File: rtl/uart_pkg.sv
// Shared types and helpers for the room-terminal UART.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  // Clocks per bit, rounded to nearest; 1 in fast-simulation mode, 0 flags a bad baud.
  function automatic int unsigned calc_div(input longint unsigned clk_freq,
                                           input longint unsigned baud,
                                           input bit              sim_fast);
    longint unsigned q;
    if (sim_fast) return 1;
    if (baud == 0) return 0;
    q = (clk_freq + baud / 2) / baud;
    return 32'(q);
  endfunction

endpackage

// File: rtl/uart_tx_param_sync_fifo.sv
// Synchronous word FIFO with exact fill level; shared by the TX and RX paths.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_n;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level_n = level + LW'(do_push) - LW'(do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two; flags are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_n;
      full  <= (level_n == LW'(DEPTH));
      empty <= (level_n == '0);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised async transmitter: FIFO-buffered words out as back-to-back RS-232 frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned SIM_FAST   = 0,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            txd,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned DIV       = calc_div(CLK_FREQ, BAUD, SIM_FAST != 0);
  localparam int unsigned STOP_CLKS = STOP_BITS * DIV;
  localparam int unsigned CNT_W     = $clog2(STOP_CLKS + 2);
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);
  localparam parity_e     PAR_MODE  = parity_e'(PARITY[1:0]);

  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_BITS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_tx_param: baud divisor evaluates below 1");
  end
  if (SIM_FAST > 1) begin : g_bad_fast
    $error("uart_tx_param: SIM_FAST must be 0 or 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two and at least 2");
  end

  tx_state_e            state;
  tx_state_e            state_n;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_n;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_n;
  logic                 par_bit;
  logic                 par_bit_n;
  logic                 txd_c;
  logic                 load_c;
  logic                 busy_c;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  // Acceptance depends only on fill state, never on a same-cycle pop.
  assign tx_ready = ~fifo_full & ~rst;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid & tx_ready),
    .pop   (load_c),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state, bit timing and line value for the current state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    par_bit_n = par_bit;
    txd_c     = 1'b1;
    load_c    = 1'b0;

    case (state)
      IDLE: begin
        txd_c = 1'b1;
        if (!fifo_empty) load_c = 1'b1;
      end
      START: begin
        txd_c = 1'b0;
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = BIT_RELOAD;
          idx_n   = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        txd_c = shift[0];
        if (cnt == '0) begin
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            if (PAR_MODE != PAR_NONE) begin
              state_n = PAR;
              cnt_n   = BIT_RELOAD;
            end else begin
              state_n = STOP;
              cnt_n   = STOP_RELOAD;
            end
          end else begin
            idx_n = idx + IDX_W'(1);
            cnt_n = BIT_RELOAD;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      PAR: begin
        txd_c = par_bit;
        if (cnt == '0) begin
          state_n = STOP;
          cnt_n   = STOP_RELOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        txd_c = 1'b1;
        if (cnt == '0) begin
          if (!fifo_empty) load_c  = 1'b1;
          else             state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Pop the head word straight into a new frame (from IDLE or the last stop clock).
    if (load_c) begin
      state_n   = START;
      cnt_n     = BIT_RELOAD;
      shift_n   = fifo_dout;
      par_bit_n = (PAR_MODE == PAR_EVEN) ? (^fifo_dout) : (~^fifo_dout);
    end

    busy_c = (state != IDLE) | (fifo_level != '0);
  end

  // State, counters and the registered line / busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par_bit <= par_bit_n;
      txd     <= txd_c;
      tx_busy <= busy_c;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param across several parameter sets.
module tb_uart_tx_param;

  logic clk;
  logic rst;
  logic d_rst_p;
  logic d_rst;
  int   checks;
  int   errors;
  int   sel;
  logic txd_m;
  logic busy_m;

  // a: fast 8N2   b: fast 7E1   c: fast 7O1   d: DIV=10 8N2   e: fast 9O2
  logic [7:0] a_data; logic a_valid; logic a_ready, a_txd, a_busy; logic [2:0] a_level;
  logic [6:0] b_data; logic b_valid; logic b_ready, b_txd, b_busy; logic [2:0] b_level;
  logic [6:0] c_data; logic c_valid; logic c_ready, c_txd, c_busy; logic [2:0] c_level;
  logic [7:0] d_data; logic d_valid; logic d_ready, d_txd, d_busy; logic [2:0] d_level;
  logic [8:0] e_data; logic e_valid; logic e_ready, e_txd, e_busy; logic [2:0] e_level;

  assign d_rst = rst | d_rst_p;

  uart_tx_param #(.SIM_FAST(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .txd(a_txd), .tx_busy(a_busy), .fifo_level(a_level));
  uart_tx_param #(.SIM_FAST(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .txd(b_txd), .tx_busy(b_busy), .fifo_level(b_level));
  uart_tx_param #(.SIM_FAST(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .tx_data(c_data), .tx_valid(c_valid), .tx_ready(c_ready),
    .txd(c_txd), .tx_busy(c_busy), .fifo_level(c_level));
  uart_tx_param #(.CLK_FREQ(1000000), .BAUD(100000), .SIM_FAST(0), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst(d_rst), .tx_data(d_data), .tx_valid(d_valid), .tx_ready(d_ready),
    .txd(d_txd), .tx_busy(d_busy), .fifo_level(d_level));
  uart_tx_param #(.SIM_FAST(1), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst(rst), .tx_data(e_data), .tx_valid(e_valid), .tx_ready(e_ready),
    .txd(e_txd), .tx_busy(e_busy), .fifo_level(e_level));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the instance under test to a common observation point.
  always_comb begin
    txd_m  = 1'b1;
    busy_m = 1'b0;
    case (sel)
      0: begin txd_m = a_txd; busy_m = a_busy; end
      1: begin txd_m = b_txd; busy_m = b_busy; end
      2: begin txd_m = c_txd; busy_m = c_busy; end
      3: begin txd_m = d_txd; busy_m = d_busy; end
      4: begin txd_m = e_txd; busy_m = e_busy; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // frame bit i is the i-th value on the line; each bit held for div clocks.
  task automatic expect_frame(input string tag, input logic [31:0] frame, input int nbits,
                              input int div, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < div; j++) begin
        check($sformatf("%s_bit%0d", tag, i), 32'(txd_m), 32'(frame[i]));
        if (j == div / 2) cap[i] = txd_m;
        wait_edges(1);
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_idle_txd"}, 32'(txd_m), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy_m), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    logic [7:0]  w4 [6];
    int          exp_e [6];

    checks = 0; errors = 0; sel = 0;
    rst = 1'b1; d_rst_p = 1'b0;
    a_data = '0; a_valid = 1'b0; b_data = '0; b_valid = 1'b0; c_data = '0; c_valid = 1'b0;
    d_data = '0; d_valid = 1'b0; e_data = '0; e_valid = 1'b0;
    w4    = '{8'h3C, 8'hA5, 8'h01, 8'hFE, 8'h80, 8'h7E};
    exp_e = '{0, 1, 2, 3, 4, 13};

    // Reset state
    wait_edges(3);
    check("rst_ready_low", 32'(a_ready), 32'd0);
    check("rst_txd", 32'({a_txd, b_txd, c_txd, d_txd, e_txd}), 32'h1F);
    check("rst_levels", 32'({a_level, b_level, c_level, d_level, e_level}), 32'd0);
    check("rst_busy", 32'({a_busy, b_busy, c_busy, d_busy, e_busy}), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'({a_ready, b_ready, c_ready, d_ready, e_ready}), 32'h1F);

    // Test 1: 0x55 8N2 one bit per clock
    sel = 0;
    a_data = 8'h55; a_valid = 1'b1;
    wait_edges(1);
    a_valid = 1'b0;
    check("t1_level_after_push", 32'(a_level), 32'd1);
    wait_edges(1);
    check("t1_latency_txd_high", 32'(txd_m), 32'd1);
    wait_edges(1);
    expect_frame("t1", 32'({2'b11, 8'h55, 1'b0}), 11, 1, cap);
    expect_idle("t1");

    // Test 2: 7E1 and 7O1 with 0x41
    sel = 1;
    check("t2e_ready", 32'(b_ready), 32'd1);
    b_data = 7'h41; b_valid = 1'b1;
    wait_edges(1);
    b_valid = 1'b0;
    wait_edges(2);
    expect_frame("t2_even", 32'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 1, cap);
    expect_idle("t2_even");
    sel = 2;
    check("t2o_ready", 32'(c_ready), 32'd1);
    c_data = 7'h41; c_valid = 1'b1;
    wait_edges(1);
    c_valid = 1'b0;
    wait_edges(2);
    expect_frame("t2_odd", 32'({1'b1, 1'b1, 7'h41, 1'b0}), 10, 1, cap);
    expect_idle("t2_odd");

    // Test 3: DIV=10, 0xA3, 110-clock frame
    sel = 3;
    d_data = 8'hA3; d_valid = 1'b1;
    wait_edges(1);
    d_valid = 1'b0;
    wait_edges(1);
    check("t3_latency_txd_high", 32'(txd_m), 32'd1);
    wait_edges(1);
    expect_frame("t3", 32'({2'b11, 8'hA3, 1'b0}), 11, 10, cap);
    check("t3_centre_data", 32'(cap[8:1]), 32'hA3);
    expect_idle("t3");

    // Test 4: six words back to back through a 4-deep FIFO
    sel = 0;
    fork
      begin : pusher
        int   e;
        int   n;
        logic r;
        e = 0; n = 0;
        a_valid = 1'b1;
        while (n < 6 && e < 40) begin
          a_data = w4[n];
          r = a_ready;
          wait_edges(1);
          if (r) begin
            check($sformatf("t4_push%0d_edge", n), 32'(e), 32'(exp_e[n]));
            n++;
          end
          if (e == 1)  check("t4_level_push_pop", 32'(a_level), 32'd1);
          if (e == 4)  check("t4_full", 32'({a_level, a_ready}), 32'({3'd4, 1'b0}));
          if (e == 12) check("t4_recover", 32'({a_level, a_ready}), 32'({3'd3, 1'b1}));
          e++;
        end
        a_valid = 1'b0;
        check("t4_push_count", 32'(n), 32'd6);
      end
      begin : frames
        logic [31:0] fcap;
        wait_edges(3);
        for (int k = 0; k < 6; k++)
          expect_frame($sformatf("t4_f%0d", k), 32'({2'b11, w4[k], 1'b0}), 11, 1, fcap);
        expect_idle("t4");
      end
    join

    // Test 5: reset during data bit 3 with two words queued
    sel = 3;
    d_valid = 1'b1;
    d_data = 8'h52; wait_edges(1);
    d_data = 8'h33; wait_edges(1);
    d_data = 8'hC4; wait_edges(1);
    d_valid = 1'b0;
    check("t5_queued", 32'(d_level), 32'd2);
    wait_edges(43);
    check("t5_bit3_low", 32'(txd_m), 32'd0);
    d_rst_p = 1'b1;
    #1;
    check("t5_ready_in_rst", 32'(d_ready), 32'd0);
    wait_edges(1);
    d_rst_p = 1'b0;
    check("t5_after_rst", 32'({d_txd, d_level, d_busy}), 32'({1'b1, 3'd0, 1'b0}));
    wait_edges(3);
    check("t5_still_idle", 32'({d_txd, d_level, d_busy, d_ready}), 32'({1'b1, 3'd0, 1'b0, 1'b1}));
    d_data = 8'h0F; d_valid = 1'b1;
    wait_edges(1);
    d_valid = 1'b0;
    wait_edges(2);
    expect_frame("t5", 32'({2'b11, 8'h0F, 1'b0}), 11, 10, cap);
    check("t5_centre_data", 32'(cap[8:1]), 32'h0F);
    expect_idle("t5");

    // Test 6: 9O2 with 0x1A5 (five ones -> parity 0)
    sel = 4;
    check("t6_ready", 32'(e_ready), 32'd1);
    e_data = 9'h1A5; e_valid = 1'b1;
    wait_edges(1);
    e_valid = 1'b0;
    wait_edges(2);
    expect_frame("t6", 32'({2'b11, 1'b0, 9'h1A5, 1'b0}), 13, 1, cap);
    expect_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the team's fixed 8N2 async transmitter, forming the serial TX path of the room-terminal UART.
- Configurable at elaboration time: data width, parity mode, stop-bit count, baud divisor.
- Accepts words through a valid/ready handshake into a small internal FIFO.
- Emits back-to-back RS-232 frames, LSB first, on a registered txd line.

Parameters:
CLK_FREQ, 50000000, clock frequency in Hz
BAUD, 115200, line rate in bit/s
SIM_FAST, 0, 1 = one bit per clock (divisor forced to 1) for fast simulation
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 2, legal 1 or 2
FIFO_DEPTH, 4, word buffer depth, power of two, at least 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tx_data  in  DATA_BITS  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  FIFO can accept; transfer occurs on a clk edge where valid and ready are both high
txd  out  1  serial line, idle high, registered
tx_busy  out  1  FIFO non-empty or frame in progress
fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently buffered

Behaviour:
- Divisor: DIV = round(CLK_FREQ/BAUD), or 1 when SIM_FAST=1.
  - Elaboration error if DIV < 1 or any parameter is out of range.
  - Bit counter reloads at every state entry, so each bit lasts exactly DIV clocks with no drift.
- Reset (rst high at an edge):
  - txd=1, FIFO flushed (fifo_level=0), FSM to IDLE, divider and bit counters cleared.
  - tx_ready=0 while rst is high; tx_busy=0.
  - Reset mid-frame aborts the frame; txd is high from the next edge.
- tx_ready = ~fifo_full & ~rst.
  - Depends only on full, not on a same-cycle pop.
  - Push while full is impossible; data is never lost or overwritten.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: txd=1. If FIFO non-empty, pop the head into the shift register, go to START.
  - START: txd=0 for DIV clocks, then DATA.
  - DATA: txd=shift[0] for DIV clocks; shift right; repeat DATA_BITS times. Then PAR if PARITY != 0, else STOP.
  - PAR: txd = ^data for even, ~^data for odd (computed on the popped word), DIV clocks, then STOP.
  - STOP: txd=1 for STOP_BITS*DIV clocks.
    - On the last STOP clock, if the FIFO is non-empty, pop and go directly to START (zero idle gap); else go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV clocks.
- Latency: word accepted at edge E0 with FIFO empty and FSM IDLE → written at E0, popped at E0+1, txd low from E0+2.
- Simultaneous push and pop: both take effect, fifo_level unchanged. A pop never occurs on an empty FIFO (no bypass path).
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level is the exact count, 0..FIFO_DEPTH.
- tx_busy = (state != IDLE) | (fifo_level != 0), registered-equivalent, glitch-free.
- txd is driven from a flop; no combinational path from any input to txd.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN).
  - tx_state_e enum (IDLE, START, DATA, PAR, STOP).
  - Function calc_div(clk_freq, baud, sim_fast).
- Sub-module sync_fifo (params WIDTH, DEPTH; ports clk, rst, push, pop, din, dout, full, empty, level). Reusable by the future RX path.
- Top module holds the divider, bit counter, shift register and FSM.

Test Plan:
1. SIM_FAST=1, 8N2, push 0x55 at E0 → txd from E0+2: 0,1,0,1,0,1,0,1,0,1,1 one bit per clock, then idle 1; tx_busy falls after the last stop bit.
2. SIM_FAST=1, DATA_BITS=7, PARITY=2 (even), STOP_BITS=1, push 0x41 → data bits 1,0,0,0,0,0,1, parity 0. Same word with PARITY=1 → parity 1.
3. DIV=10, 8N2, push 0xA3 → every bit exactly 10 clocks, frame 110 clocks, sampling at bit centres recovers 0xA3.
4. FIFO_DEPTH=4, SIM_FAST=1, tx_valid held high with 6 words:
   - tx_ready drops when fifo_level reaches 4 and recovers on pops.
   - All 6 frames are sent in order with no idle clock between the stop bit and the next start bit.
5. DIV=10, rst asserted for 1 cycle during data bit 3 of a frame with 2 words queued → next edge txd=1, fifo_level=0, tx_busy=0. A following push of 0x0F is sent correctly.
6. SIM_FAST=1, DATA_BITS=9, PARITY=1 (odd), push 0x1A5 (five ones) → 9 data bits LSB first, parity 0, two stop bits.
